// File: rtl/cdb_arbiter_pkg.sv
// Shared result types for the common data bus: one broadcast beat is
// tag + ROB index + 32-bit data.
package rv32i_types;
  localparam int TAG_W     = 4;
  localparam int ROB_DEPTH = 16;
  localparam int PTR_W     = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [PTR_W-1:0] inst_id;
    logic [31:0]      wdata;
  } cdb_result_t;
endpackage

// File: rtl/cdb_arbiter_fu_fifo.sv
// Per-FU result queue: circular buffer with count, no write-to-head bypass.
// Flush empties the queue and blocks push/pop for that cycle.
module cdb_fu_fifo
  import rv32i_types::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  cdb_result_t      din,
  input  logic             pop,
  output cdb_result_t      head,
  output logic [CNT_W-1:0] count,
  output logic             ready
);
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  cdb_result_t      mem_q [DEPTH];
  cdb_result_t      mem_d [DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = din;
        wptr_d        = ptr_inc(wptr_q);
      end
      if (pop) rptr_d = ptr_inc(rptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; count guards every read.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign head  = mem_q[rptr_q];
  assign count = count_q;
  assign ready = (count_q < CNT_W'(DEPTH)) && !flush;
endmodule

// File: rtl/cdb_arbiter.sv
// CDB master: queues FU results and broadcasts one per cycle, chosen
// round-robin starting after the last granted FU.
module cdb_arbiter #(
  parameter int TAG_W      = rv32i_types::TAG_W,
  parameter int ROB_DEPTH  = rv32i_types::ROB_DEPTH,
  parameter int PTR_W      = $clog2(ROB_DEPTH),
  parameter int N_FU       = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [N_FU-1:0]         fu_valid,
  output logic [N_FU-1:0]         fu_ready,
  input  logic [N_FU*TAG_W-1:0]   fu_tag,
  input  logic [N_FU*PTR_W-1:0]   fu_inst_id,
  input  logic [N_FU*32-1:0]      fu_wdata,
  output logic                    cdb_wr,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [PTR_W-1:0]        cdb_inst_id,
  output logic [31:0]             cdb_wdata,
  output logic [N_FU-1:0]         cdb_grant
);
  import rv32i_types::*;

  localparam int RR_W  = (N_FU > 1) ? $clog2(N_FU) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [N_FU-1:0]  req, push, ready;
  cdb_result_t      head [N_FU];
  logic [CNT_W-1:0] cnt  [N_FU];
  logic [RR_W-1:0]  rr_ptr_q, rr_ptr_d, gidx;
  logic             found;
  logic [N_FU-1:0]  grant;
  cdb_result_t      bcast;
  int               idx;

  for (genvar g = 0; g < N_FU; g++) begin : g_fu
    cdb_result_t din;
    assign din.tag     = fu_tag[g*TAG_W +: TAG_W];
    assign din.inst_id = fu_inst_id[g*PTR_W +: PTR_W];
    assign din.wdata   = fu_wdata[g*32 +: 32];
    assign push[g]     = fu_valid[g] && ready[g];
    assign req[g]      = (cnt[g] != '0);

    cdb_fu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[g]),
      .din   (din),
      .pop   (grant[g]),
      .head  (head[g]),
      .count (cnt[g]),
      .ready (ready[g])
    );

    // Tag 0 means "no producer"; an FU completing with it is a bug upstream.
    a_tag_nonzero: assert property (@(posedge clk) disable iff (rst)
      push[g] |-> (fu_tag[g*TAG_W +: TAG_W] != '0));
  end

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int k = 1; k <= N_FU; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_FU;
      if (!found && req[RR_W'(idx)]) begin
        found = 1'b1;
        gidx  = RR_W'(idx);
      end
    end
    if (flush) found = 1'b0;
    grant = '0;
    if (found) grant[gidx] = 1'b1;
    rr_ptr_d = found ? gidx : rr_ptr_q;
    bcast    = found ? head[gidx] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= RR_W'(N_FU - 1);
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign fu_ready    = ready;
  assign cdb_grant   = grant;
  assign cdb_wr      = found;
  assign cdb_tag     = bcast.tag;
  assign cdb_inst_id = bcast.inst_id;
  assign cdb_wdata   = bcast.wdata;
endmodule
